adc_frame_packager: RTL and testbench

Parametrised successor to the fixed 6×16-bit ADC byte packager. Snapshots ADC_COUNT channels of ADC_DATA_WIDTH-bit samples and emits one framed byte stream per sync_pulse: START_BYTE, then sample bytes, then END_BYTE. Uses a valid/ready output handshake in place of a busy input. Sits between the ADC capture front-end and the UART/FIFO byte transport.

---
 rtl/adc_frame_packager_pkg.sv | 17 +
 rtl/adc_frame_packager_if.sv | 27 ++
 rtl/adc_frame_packager_byte_select.sv | 31 +++
 rtl/adc_frame_packager.sv | 136 +++++++++++++
 tb/tb_adc_frame_packager.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/adc_frame_packager_pkg.sv
// Shared encodings and helpers for the ADC frame packagers.
package adc_packager_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_CHK   = 3'd3;
    localparam logic [2:0] ST_END   = 3'd4;

    localparam logic [7:0] DEFAULT_START_BYTE = 8'h00;
    localparam logic [7:0] DEFAULT_END_BYTE   = 8'hFF;

    function automatic int bytes_per_sample(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/adc_frame_packager_if.sv
// Sample input, frame request and byte-stream handshake between the capture
// front-end, the packager and the byte transport.
interface adc_frame_packager_if #(
    parameter int ADC_DATA_WIDTH = 16,
    parameter int ADC_COUNT      = 6
) ();

    logic [ADC_COUNT*ADC_DATA_WIDTH-1:0] data_adc;
    logic                                write_enable;
    logic                                sync_pulse;
    logic                                out_ready;
    logic [7:0]                          data_out;
    logic                                data_valid;
    logic                                frame_active;
    logic                                overrun;

    modport master (
        output data_adc, write_enable, sync_pulse, out_ready,
        input  data_out, data_valid, frame_active, overrun
    );

    modport slave (
        input  data_adc, write_enable, sync_pulse, out_ready,
        output data_out, data_valid, frame_active, overrun
    );

endinterface

// File: rtl/adc_frame_packager_byte_select.sv
// Picks one byte (MSB byte first) of one channel out of a flattened sample word.
// Purely combinational: zero latency, no backpressure.
module adc_byte_select
    import adc_packager_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = 16,
    parameter int ADC_COUNT      = 6,
    parameter int CHAN_W         = $clog2(ADC_COUNT + 1),
    parameter int BYTE_W         = $clog2(ADC_DATA_WIDTH / 8 + 1)
) (
    input  logic [ADC_COUNT*ADC_DATA_WIDTH-1:0] snapshot,
    input  logic [CHAN_W-1:0]                   chan_idx,
    input  logic [BYTE_W-1:0]                   byte_idx,
    output logic [7:0]                          byte_out
);

    localparam int BYTES = bytes_per_sample(ADC_DATA_WIDTH);

    // Out-of-range indices (e.g. the terminal chan_idx) yield 0.
    always_comb begin
        byte_out = 8'h00;
        for (int c = 0; c < ADC_COUNT; c++) begin
            for (int b = 0; b < BYTES; b++) begin
                if (chan_idx == CHAN_W'(c) && byte_idx == BYTE_W'(b)) begin
                    byte_out = snapshot[c*ADC_DATA_WIDTH + (BYTES-1-b)*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/adc_frame_packager.sv
// Frames a snapshot of all ADC channels as START, sample bytes, [XOR checksum if PACKAGER_CHECKSUM_EN], END.
// First byte valid the cycle after sync_pulse; one byte per cycle while out_ready, byte held while !out_ready.
module adc_frame_packager
    import adc_packager_pkg::*;
#(
    parameter int         ADC_DATA_WIDTH = 16,
    parameter int         ADC_COUNT      = 6,
    parameter logic [7:0] START_BYTE     = DEFAULT_START_BYTE,
    parameter logic [7:0] END_BYTE       = DEFAULT_END_BYTE
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_frame_packager_if.slave  bus
);

    localparam int BYTES  = bytes_per_sample(ADC_DATA_WIDTH);
    localparam int CHAN_W = $clog2(ADC_COUNT + 1);
    localparam int BYTE_W = $clog2(BYTES + 1);
    localparam int SAMP_W = ADC_COUNT * ADC_DATA_WIDTH;

    logic [SAMP_W-1:0] shadow;
    logic [SAMP_W-1:0] snapshot;
    logic [2:0]        state;
    logic [CHAN_W-1:0] chan_idx;
    logic [BYTE_W-1:0] byte_idx;
    logic              overrun_q;
    logic [7:0]        sel_byte;
    logic [7:0]        out_byte;
    logic              xfer;
    logic              chan_wrap;
    logic              last_byte;
`ifdef PACKAGER_CHECKSUM_EN
    logic [7:0]        chk_acc;
`endif

    adc_byte_select #(
        .ADC_DATA_WIDTH (ADC_DATA_WIDTH),
        .ADC_COUNT      (ADC_COUNT),
        .CHAN_W         (CHAN_W),
        .BYTE_W         (BYTE_W)
    ) u_byte_select (
        .snapshot (snapshot),
        .chan_idx (chan_idx),
        .byte_idx (byte_idx),
        .byte_out (sel_byte)
    );

    assign xfer      = (state != ST_IDLE) && bus.out_ready;
    assign chan_wrap = (byte_idx == BYTE_W'(BYTES - 1));
    assign last_byte = chan_wrap && (chan_idx == CHAN_W'(ADC_COUNT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            snapshot  <= '0;
            state     <= ST_IDLE;
            chan_idx  <= '0;
            byte_idx  <= '0;
            overrun_q <= 1'b0;
`ifdef PACKAGER_CHECKSUM_EN
            chk_acc   <= 8'h00;
`endif
        end else begin
            overrun_q <= bus.sync_pulse && (state != ST_IDLE);
            if (bus.write_enable) begin
                shadow <= bus.data_adc;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.sync_pulse) begin
                        // A write landing on the start cycle must make it into this frame.
                        snapshot <= bus.write_enable ? bus.data_adc : shadow;
                        chan_idx <= '0;
                        byte_idx <= '0;
                        state    <= ST_START;
`ifdef PACKAGER_CHECKSUM_EN
                        chk_acc  <= 8'h00;
`endif
                    end
                end
                ST_START: begin
                    if (xfer) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (xfer) begin
`ifdef PACKAGER_CHECKSUM_EN
                        chk_acc <= chk_acc ^ sel_byte;
`endif
                        if (chan_wrap) begin
                            byte_idx <= '0;
                            chan_idx <= chan_idx + CHAN_W'(1);
                        end else begin
                            byte_idx <= byte_idx + BYTE_W'(1);
                        end
                        if (last_byte) begin
`ifdef PACKAGER_CHECKSUM_EN
                            state <= ST_CHK;
`else
                            state <= ST_END;
`endif
                        end
                    end
                end
`ifdef PACKAGER_CHECKSUM_EN
                ST_CHK: begin
                    if (xfer) state <= ST_END;
                end
`endif
                ST_END: begin
                    if (xfer) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from registered state only, so they cannot move while a byte waits for out_ready.
    always_comb begin
        out_byte = 8'h00;
        case (state)
            ST_START: out_byte = START_BYTE;
            ST_DATA:  out_byte = sel_byte;
`ifdef PACKAGER_CHECKSUM_EN
            ST_CHK:   out_byte = chk_acc;
`endif
            ST_END:   out_byte = END_BYTE;
            default:  out_byte = 8'h00;
        endcase
    end

    assign bus.data_out     = out_byte;
    assign bus.data_valid   = (state != ST_IDLE);
    assign bus.frame_active = (state != ST_IDLE);
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_adc_frame_packager.sv
// Directed bench for adc_frame_packager: default 6x16 instance plus a 2x24 instance.
module tb_adc_frame_packager;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adc_frame_packager_if #(.ADC_DATA_WIDTH(16), .ADC_COUNT(6)) if_a ();
    adc_frame_packager_if #(.ADC_DATA_WIDTH(24), .ADC_COUNT(2)) if_b ();

    adc_frame_packager #(.ADC_DATA_WIDTH(16), .ADC_COUNT(6)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    adc_frame_packager #(.ADC_DATA_WIDTH(24), .ADC_COUNT(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    typedef struct {
        logic       rdy;
        logic       sync;
        logic       we;
        logic       vld;
        logic [7:0] dat;
        logic       act;
        logic       ovr;
    } vec_t;

    vec_t       tab[$];
    logic [7:0] exp_bytes[$];
    int         n_cmp = 0;
    int         n_err = 0;

    localparam logic [95:0] D1 = {16'h0B0C, 16'h090A, 16'h0708, 16'h0506, 16'h0304, 16'h0102};
    localparam logic [95:0] DA = {6{16'hAAAA}};
    localparam logic [95:0] D5 = {6{16'h5555}};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // Expected frame for the 6x16 instance: START, ch0 MSB..ch5 LSB, [checksum], END.
    task automatic make_frame_a(input logic [95:0] flat);
        logic [7:0] x;
        x = 8'h00;
        exp_bytes.delete();
        exp_bytes.push_back(8'h00);
        for (int k = 0; k < 6; k++) begin
            exp_bytes.push_back(flat[k*16+8 +: 8]);
            exp_bytes.push_back(flat[k*16 +: 8]);
            x = x ^ flat[k*16+8 +: 8] ^ flat[k*16 +: 8];
        end
`ifdef PACKAGER_CHECKSUM_EN
        exp_bytes.push_back(x);
`endif
        exp_bytes.push_back(8'hFF);
    endtask

    task automatic build_tab(input bit toggle, input int sync_at, input int we_at);
        vec_t v;
        int   n;
        n = exp_bytes.size();
        tab.delete();
        for (int k = 0; k < n; k++) begin
            if (toggle && k > 0 && k < n - 1) begin
                v = '{rdy: 1'b0, sync: 1'b0, we: 1'b0, vld: 1'b1, dat: exp_bytes[k], act: 1'b1, ovr: 1'b0};
                tab.push_back(v);
            end
            v = '{rdy: 1'b1, sync: (k == sync_at), we: (k == we_at), vld: 1'b1,
                  dat: exp_bytes[k], act: 1'b1, ovr: 1'b0};
            tab.push_back(v);
        end
        for (int k = 0; k < 3; k++) begin
            v = '{rdy: 1'b1, sync: 1'b0, we: 1'b0, vld: 1'b0, dat: 8'h00, act: 1'b0, ovr: 1'b0};
            tab.push_back(v);
        end
        for (int j = 1; j < tab.size(); j++) tab[j].ovr = tab[j-1].sync;
    endtask

    task automatic apply_tab(input string tag);
        for (int i = 0; i < tab.size(); i++) begin
            if_a.out_ready    = tab[i].rdy;
            if_a.sync_pulse   = tab[i].sync;
            if_a.write_enable = tab[i].we;
            check($sformatf("%s[%0d].valid", tag, i), {7'd0, if_a.data_valid}, {7'd0, tab[i].vld});
            if (tab[i].vld) check($sformatf("%s[%0d].data", tag, i), if_a.data_out, tab[i].dat);
            check($sformatf("%s[%0d].active", tag, i), {7'd0, if_a.frame_active}, {7'd0, tab[i].act});
            check($sformatf("%s[%0d].overrun", tag, i), {7'd0, if_a.overrun}, {7'd0, tab[i].ovr});
            @(negedge clk);
        end
        if_a.sync_pulse   = 1'b0;
        if_a.write_enable = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where START should be visible.
    task automatic start_a(input bit we);
        if_a.write_enable = we;
        if_a.sync_pulse   = 1'b1;
        @(negedge clk);
        if_a.write_enable = 1'b0;
        if_a.sync_pulse   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_b[$];

        if_a.data_adc = '0; if_a.write_enable = 0; if_a.sync_pulse = 0; if_a.out_ready = 1;
        if_b.data_adc = '0; if_b.write_enable = 0; if_b.sync_pulse = 0; if_b.out_ready = 1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.valid",   {7'd0, if_a.data_valid},   8'h00);
        check("reset.data",    if_a.data_out,             8'h00);
        check("reset.active",  {7'd0, if_a.frame_active}, 8'h00);
        check("reset.overrun", {7'd0, if_a.overrun},      8'h00);
        check("reset.b_valid", {7'd0, if_b.data_valid},   8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame, ready always high.
        if_a.data_adc = D1;
        if_a.write_enable = 1'b1;
        @(negedge clk);
        if_a.write_enable = 1'b0;
        make_frame_a(D1);
        build_tab(1'b0, -1, -1);
        start_a(1'b0);
        apply_tab("basic");

        // Same frame with ready alternating; each byte must hold through the stall.
        build_tab(1'b1, -1, -1);
        start_a(1'b0);
        apply_tab("toggle");

        // sync during byte 5 is dropped with a single overrun pulse.
        build_tab(1'b0, 5, -1);
        start_a(1'b0);
        apply_tab("overrun");

        // New data written mid-frame only shows up in the next frame.
        if_a.data_adc = DA;
        build_tab(1'b0, -1, 3);
        start_a(1'b0);
        apply_tab("wr_mid");
        make_frame_a(DA);
        build_tab(1'b0, -1, -1);
        start_a(1'b0);
        apply_tab("wr_next");

        // write_enable coinciding with sync feeds the snapshot directly.
        if_a.data_adc = D5;
        make_frame_a(D5);
        build_tab(1'b0, -1, -1);
        start_a(1'b1);
        apply_tab("wr_same");

        // 24-bit x 2 channel instance.
        exp_b = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
`ifdef PACKAGER_CHECKSUM_EN
        exp_b.push_back(8'h2E);
`endif
        exp_b.push_back(8'hFF);
        if_b.data_adc     = {24'h789ABC, 24'h123456};
        if_b.write_enable = 1'b1;
        if_b.sync_pulse   = 1'b1;
        @(negedge clk);
        if_b.write_enable = 1'b0;
        if_b.sync_pulse   = 1'b0;
        for (int i = 0; i < exp_b.size(); i++) begin
            check($sformatf("w24[%0d].valid", i), {7'd0, if_b.data_valid}, 8'h01);
            check($sformatf("w24[%0d].data", i), if_b.data_out, exp_b[i]);
            @(negedge clk);
        end
        check("w24.end_valid",  {7'd0, if_b.data_valid},   8'h00);
        check("w24.end_active", {7'd0, if_b.frame_active}, 8'h00);

        // Reset in the middle of DATA aborts the frame; shadow is cleared too.
        start_a(1'b0);
        repeat (4) @(negedge clk);
        check("rst_mid.in_data", if_a.data_out, 8'h55);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.valid",  {7'd0, if_a.data_valid},   8'h00);
        check("rst_mid.active", {7'd0, if_a.frame_active}, 8'h00);
        check("rst_mid.data",   if_a.data_out,             8'h00);
        rst = 1'b0;
        make_frame_a(96'd0);
        build_tab(1'b0, -1, -1);
        start_a(1'b0);
        apply_tab("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
